// File: rtl/spi_mem_if.sv
// rtl/spi_mem_if.sv - SAP-3 memory stage backed by a mode-0 SPI SRAM
module spi_mem_if #(
  parameter int         ADDR_W  = 16,
  parameter int         CLK_DIV = 2,
  parameter logic [7:0] RD_CMD  = 8'h03,
  parameter logic [7:0] WR_CMD  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus,
  input  logic        mar_we,
  input  logic        ram_we,
  output logic [7:0]  mem_out,
  output logic        ready,
  output logic        err,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt;
  logic [5:0]        half_cnt;   // counts sck toggles, 64 per transaction
  logic [31:0]       tx_sr;      // {opcode, address, write byte}, shifted out MSB first
  logic [7:0]        rx_sr;
  logic [7:0]        wdata;
  logic              is_wr;
  logic [ADDR_W-1:0] mar;
  logic              accept_rd, accept_wr, tick;

  assign ready     = (state == S_IDLE);
  // mar_we has priority; a simultaneous ram_we is dropped
  assign accept_rd = ready && mar_we;
  assign accept_wr = ready && ram_we && !mar_we;
  assign tick      = (div_cnt == DIV_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: phase boundaries fall on the sck falling edge ending each field
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_rd || accept_wr) state_nxt = S_START;
      S_START: state_nxt = S_CMD;
      S_CMD:   if (tick && half_cnt == 6'd15) state_nxt = S_ADDR;
      S_ADDR:  if (tick && half_cnt == 6'd47) state_nxt = S_DATA;
      S_DATA:  if (tick && half_cnt == 6'd63) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request capture, SPI shifting, error flag and result update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar      <= '0;
      mem_out  <= 8'h00;
      err      <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= 6'd0;
      tx_sr    <= 32'h0;
      rx_sr    <= 8'h00;
      wdata    <= 8'h00;
      is_wr    <= 1'b0;
    end else begin
      if ((mar_we || ram_we) && !ready) err <= 1'b1;
      if (ready && mar_we && ram_we)    err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (accept_rd) begin
            mar   <= bus[ADDR_W-1:0];
            is_wr <= 1'b0;
            tx_sr <= {RD_CMD, 16'(bus[ADDR_W-1:0]), 8'h00};
          end else if (accept_wr) begin
            is_wr <= 1'b1;
            wdata <= bus[7:0];
            tx_sr <= {WR_CMD, 16'(mar), bus[7:0]};
          end
        end
        S_START: begin
          // cs_n falls with the first bit already on mosi
          spi_cs_n <= 1'b0;
          spi_sck  <= 1'b0;
          spi_mosi <= tx_sr[31];
          tx_sr    <= {tx_sr[30:0], 1'b0};
          div_cnt  <= '0;
          half_cnt <= 6'd0;
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (tick) begin
            div_cnt  <= '0;
            spi_sck  <= ~spi_sck;
            half_cnt <= half_cnt + 6'd1;
            if (spi_sck) begin
              // falling edge: present the next bit, none after the last one
              if (half_cnt != 6'd63) begin
                spi_mosi <= tx_sr[31];
                tx_sr    <= {tx_sr[30:0], 1'b0};
              end
            end else begin
              rx_sr <= {rx_sr[6:0], spi_miso};
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_DONE: begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
          mem_out  <= is_wr ? wdata : rx_sr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_if.sv
// tb/tb_spi_mem_if.sv - self-checking bench for spi_mem_if with an SPI SRAM model
module tb_spi_mem_if;

  localparam int CLK_DIV = 2;
  localparam int LAT     = 64 * CLK_DIV + 2;

  logic        clk = 1'b0;
  logic        rst_n, mar_we, ram_we, spi_miso;
  logic [15:0] bus;
  logic [7:0]  mem_out;
  logic        ready, err, spi_cs_n, spi_sck, spi_mosi;

  logic [7:0]  o1_mem, o4_mem;
  logic        o1_ready, o1_err, o1_cs, o1_sck, o1_mosi;
  logic        o4_ready, o4_err, o4_cs, o4_sck, o4_mosi;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_mem_if #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mar_we(mar_we), .ram_we(ram_we),
    .mem_out(mem_out), .ready(ready), .err(err), .spi_cs_n(spi_cs_n),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_mem_if #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mar_we(mar_we), .ram_we(ram_we),
    .mem_out(o1_mem), .ready(o1_ready), .err(o1_err), .spi_cs_n(o1_cs),
    .spi_sck(o1_sck), .spi_mosi(o1_mosi), .spi_miso(1'b0)
  );

  spi_mem_if #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mar_we(mar_we), .ram_we(ram_we),
    .mem_out(o4_mem), .ready(o4_ready), .err(o4_err), .spi_cs_n(o4_cs),
    .spi_sck(o4_sck), .spi_mosi(o4_mosi), .spi_miso(1'b0)
  );

  // SPI SRAM model: 03 = read, 02 = write, 16-bit address
  logic [7:0]  mem [0:65535];
  int          bits;
  logic [31:0] word;
  logic [7:0]  cmd_r, tmp_b;
  logic [15:0] addr_r;
  logic [31:0] txn_q[$];
  int          txn_bits_q[$];

  always @(negedge spi_cs_n) begin
    bits = 0;
    word = 32'h0;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      word = {word[30:0], spi_mosi};
      bits++;
      if (bits == 24) begin
        cmd_r  = word[23:16];
        addr_r = word[15:0];
      end
      if (bits == 32 && cmd_r == 8'h02) mem[addr_r] = word[7:0];
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && bits >= 24 && bits < 32 && cmd_r == 8'h03) begin
      tmp_b    = mem[addr_r];
      spi_miso = tmp_b[31 - bits];
    end
  end

  always @(posedge spi_cs_n) begin
    txn_q.push_back(word);
    txn_bits_q.push_back(bits);
  end

  // Mode-0 protocol monitor sampled once per clock
  int   viol = 0;
  logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (spi_mosi !== prev_mosi && spi_sck === 1'b1) viol++;
      if (prev_cs === 1'b0 && spi_cs_n === 1'b1 && prev_sck === 1'b1) viol++;
      if (spi_sck !== prev_sck && prev_cs === 1'b1 && spi_cs_n === 1'b1) viol++;
    end
    prev_cs = spi_cs_n; prev_sck = spi_sck; prev_mosi = spi_mosi;
  end

  logic [15:0] ref_mar;

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input logic mw, input logic rw, input logic [15:0] b,
                        output int lat, output logic stable);
    logic [7:0] m0;
    @(negedge clk); mar_we = mw; ram_we = rw; bus = b;
    @(posedge clk); #1; mar_we = 1'b0; ram_we = 1'b0;
    m0 = mem_out; stable = 1'b1; lat = 0;
    while (!ready && lat < 1000) begin
      @(posedge clk); #1; lat++;
      if (!ready && mem_out !== m0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || mem_out !== 8'h00 ||
        err !== 1'b0 || spi_mosi !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: ready=%b cs_n=%b sck=%b mem_out=%h err=%b mosi=%b required 1 1 0 00 0 0",
               ready, spi_cs_n, spi_sck, mem_out, err, spi_mosi);
    end
  endtask

  task automatic test_read_write();
    int lat; logic st; logic [31:0] w;
    mem[16'h1234] = 8'hA5;
    txn_q.delete(); txn_bits_q.delete();
    do_txn(1'b1, 1'b0, 16'h1234, lat, st);
    ref_mar = 16'h1234;
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL read_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (mem_out !== 8'hA5 || !st) begin
      failures++; $display("FAIL read_data: mem_out=%h stable=%b required A5 1", mem_out, st);
    end
    w = (txn_q.size() == 1) ? txn_q[0] : 32'h0;
    checks++;
    if (txn_q.size() != 1 || w[31:8] !== 24'h031234 || txn_bits_q[0] != 32) begin
      failures++; $display("FAIL read_mosi: txns=%0d word=%h required 1 031234xx", txn_q.size(), w);
    end
    txn_q.delete(); txn_bits_q.delete();
    do_txn(1'b0, 1'b1, 16'h005A, lat, st);
    w = (txn_q.size() == 1) ? txn_q[0] : 32'h0;
    checks++;
    if (lat !== LAT || mem_out !== 8'h5A || !st) begin
      failures++; $display("FAIL write_result: lat=%0d mem_out=%h required %0d 5A", lat, mem_out, LAT);
    end
    checks++;
    if (txn_q.size() != 1 || w !== 32'h0212345A || mem[16'h1234] !== 8'h5A || err !== 1'b0) begin
      failures++;
      $display("FAIL write_mosi: txns=%0d word=%h model=%h err=%b required 1 0212345A 5A 0",
               txn_q.size(), w, mem[16'h1234], err);
    end
  endtask

  task automatic test_random();
    int lat; logic st; logic [31:0] w, exp_w, mask; logic [7:0] exp_out, d; logic [15:0] a;
    for (int i = 0; i < 12; i++) begin
      txn_q.delete(); txn_bits_q.delete();
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        exp_out = mem[a];
        exp_w = {8'h03, a, 8'h00}; mask = 32'hFFFFFF00;
        do_txn(1'b1, 1'b0, a, lat, st);
        ref_mar = a;
      end else begin
        d = 8'($urandom);
        exp_out = d;
        exp_w = {8'h02, ref_mar, d}; mask = 32'hFFFFFFFF;
        do_txn(1'b0, 1'b1, {8'($urandom), d}, lat, st);
      end
      w = (txn_q.size() == 1) ? txn_q[0] : 32'h0;
      checks++;
      if (lat !== LAT || mem_out !== exp_out || !st || txn_q.size() != 1 ||
          (w & mask) !== (exp_w & mask) || mem[ref_mar] !== exp_out) begin
        failures++;
        $display("FAIL random_op%0d: lat=%0d mem_out=%h word=%h model=%h required %0d %h %h %h",
                 i, lat, mem_out, w, mem[ref_mar], LAT, exp_out, exp_w & mask, exp_out);
      end
    end
  endtask

  task automatic test_busy_strobe();
    int lat; logic [15:0] a; logic [7:0] exp_out; logic [31:0] w;
    a = 16'($urandom); exp_out = mem[a];
    txn_q.delete(); txn_bits_q.delete();
    @(negedge clk); mar_we = 1'b1; bus = a;
    @(posedge clk); #1; mar_we = 1'b0; lat = 0;
    while (!ready && lat < 1000) begin
      if (lat == 40) begin
        @(negedge clk); ram_we = 1'b1; bus = {8'h00, ~exp_out};
      end
      @(posedge clk); #1; ram_we = 1'b0; lat++;
    end
    ref_mar = a;
    w = (txn_q.size() == 1) ? txn_q[0] : 32'h0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL busy_err: err=%b required 1", err); end
    checks++;
    if (lat !== LAT || mem_out !== exp_out || mem[a] !== exp_out || txn_q.size() != 1 || w[31:24] !== 8'h03) begin
      failures++;
      $display("FAIL busy_read: lat=%0d mem_out=%h model=%h txns=%0d required %0d %h %h 1",
               lat, mem_out, mem[a], txn_q.size(), LAT, exp_out, exp_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic st; logic [7:0] old; logic [31:0] w;
    old = mem[ref_mar];
    txn_q.delete(); txn_bits_q.delete();
    @(negedge clk); ram_we = 1'b1; bus = {8'h00, ~old};
    @(posedge clk); #1; ram_we = 1'b0;
    repeat (20 * CLK_DIV) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (spi_cs_n !== 1'b1 || ready !== 1'b1 || spi_sck !== 1'b0 || err !== 1'b0 || mem_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_state: cs_n=%b ready=%b sck=%b err=%b mem_out=%h required 1 1 0 0 00",
               spi_cs_n, ready, spi_sck, err, mem_out);
    end
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (mem[ref_mar] !== old || txn_bits_q.size() != 1 || txn_bits_q[0] >= 32) begin
      failures++; $display("FAIL reset_mid_model: model=%h required %h (aborted)", mem[ref_mar], old);
    end
    ref_mar = 16'h0000;
    txn_q.delete(); txn_bits_q.delete();
    do_txn(1'b0, 1'b1, 16'h0077, lat, st);
    w = (txn_q.size() == 1) ? txn_q[0] : 32'h0;
    checks++;
    if (w !== 32'h02000077 || mem[16'h0000] !== 8'h77 || mem_out !== 8'h77) begin
      failures++; $display("FAIL reset_mar_zero: word=%h mem_out=%h required 02000077 77", w, mem_out);
    end
  endtask

  task automatic test_simultaneous();
    int lat; logic st; logic [7:0] exp_out; logic [31:0] w;
    exp_out = mem[16'hFFFF];
    txn_q.delete(); txn_bits_q.delete();
    do_txn(1'b1, 1'b1, 16'hFFFF, lat, st);
    ref_mar = 16'hFFFF;
    w = (txn_q.size() == 1) ? txn_q[0] : 32'h0;
    checks++;
    if (err !== 1'b1 || mem_out !== exp_out || txn_q.size() != 1 || w[31:8] !== 24'h03FFFF) begin
      failures++;
      $display("FAIL simultaneous: err=%b mem_out=%h txns=%0d word=%h required 1 %h 1 03FFFFxx",
               err, mem_out, txn_q.size(), w, exp_out);
    end
  endtask

  task automatic test_latency_div();
    int l1, l2, l4;
    do_reset();
    l1 = 0; l2 = 0; l4 = 0;
    @(negedge clk); mar_we = 1'b1; bus = 16'($urandom);
    @(posedge clk); #1; mar_we = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (o1_ready && l1 == 0) l1 = k;
      if (ready && l2 == 0)    l2 = k;
      if (o4_ready && l4 == 0) l4 = k;
    end
    checks++;
    if (l1 != 66) begin failures++; $display("FAIL latency_div1: got %0d required 66", l1); end
    checks++;
    if (l2 != LAT) begin failures++; $display("FAIL latency_div2: got %0d required %0d", l2, LAT); end
    checks++;
    if (l4 != 258) begin failures++; $display("FAIL latency_div4: got %0d required 258", l4); end
  endtask

  initial begin
    rst_n = 1'b0; mar_we = 1'b0; ram_we = 1'b0; bus = 16'h0; spi_miso = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_read_write();
    test_random();
    test_busy_strobe();
    test_reset_mid();
    test_simultaneous();
    test_latency_div();
    checks++;
    if (viol != 0) begin failures++; $display("FAIL spi_mode0: violations=%0d required 0", viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
